// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control for vector multi-beat ops, load-use hazards and taken branches
module hazard_control_unit #(
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Valid_EX_i,
  input  logic [1:0]       OpType_EX_i,
  input  logic             RegFile_WE_EX_i,
  input  logic             WBSelect_EX_i,
  input  logic [4:0]       A3_EX_i,
  input  logic [4:0]       A1_ID_i,
  input  logic [4:0]       A2_ID_i,
  input  logic             Use1_ID_i,
  input  logic             Use2_ID_i,
  input  logic             BranchTaken_EX_i,
  output logic             Enable_PC_o,
  output logic             Enable_IFID_o,
  output logic             Enable_IDEX_o,
  output logic             Flush_IFID_o,
  output logic             Flush_IDEX_o,
  output logic             Bubble_EXMEM_o,
  output logic             Busy_o,
  output logic [2:0]       Beat_o,
  output logic [CNT_W-1:0] StallCount_o
);
  localparam int B = (V + LANES - 1) / LANES;
  localparam logic [2:0] LAST = 3'(B - 1);
  localparam logic MULTI = B > 1;
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic vt, lu, vh, br;
  assign vt = Valid_EX_i & (OpType_EX_i == 2'b01);
  assign lu = Valid_EX_i & RegFile_WE_EX_i & WBSelect_EX_i &
              ((Use1_ID_i & (A1_ID_i == A3_EX_i)) | (Use2_ID_i & (A2_ID_i == A3_EX_i)));
  // beat_q is held at 0 in IDLE, so it serves directly as Beat_o in both states
  assign vh = vt & (beat_q < LAST);
  assign br = BranchTaken_EX_i;
  assign Enable_PC_o    = ~RST & (br | ~(vh | lu));
  assign Enable_IFID_o  = Enable_PC_o;
  assign Enable_IDEX_o  = ~RST & (br | ~vh);
  assign Flush_IFID_o   = ~RST & br;
  assign Flush_IDEX_o   = ~RST & (br | (~vh & lu));
  assign Bubble_EXMEM_o = ~RST & ~br & vh;
  assign Busy_o         = ~RST & (state_q == BUSY);
  assign Beat_o         = beat_q;
  assign StallCount_o   = cnt_q;
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (state_q == IDLE) begin
      if (vt && MULTI) begin
        state_d = BUSY;
        beat_d  = 3'd1;
      end
    end else if (beat_q == LAST) begin
      state_d = IDLE;
      beat_d  = 3'd0;
    end else begin
      beat_d = beat_q + 3'd1;
    end
    cnt_d = (!Enable_PC_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors against default, single-beat (LANES=20) and 2-bit counter instances
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst;
  logic valid, we, wbsel, use1, use2, br;
  logic [1:0] op;
  logic [4:0] a3, a1, a2;
  logic en_pc, en_ifid, en_idex, fl_ifid, fl_idex, bub, busy;
  logic [2:0] beat;
  logic [15:0] cnt;
  logic en_pc1, en_ifid1, en_idex1, fl_ifid1, fl_idex1, bub1, busy1;
  logic [2:0] beat1;
  logic [15:0] cnt1;
  logic en_pc2, en_ifid2, en_idex2, fl_ifid2, fl_idex2, bub2, busy2;
  logic [2:0] beat2;
  logic [1:0] cnt2;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  hazard_control_unit dut (
    .CLK(clk), .RST(rst), .Valid_EX_i(valid), .OpType_EX_i(op), .RegFile_WE_EX_i(we),
    .WBSelect_EX_i(wbsel), .A3_EX_i(a3), .A1_ID_i(a1), .A2_ID_i(a2), .Use1_ID_i(use1),
    .Use2_ID_i(use2), .BranchTaken_EX_i(br), .Enable_PC_o(en_pc), .Enable_IFID_o(en_ifid),
    .Enable_IDEX_o(en_idex), .Flush_IFID_o(fl_ifid), .Flush_IDEX_o(fl_idex),
    .Bubble_EXMEM_o(bub), .Busy_o(busy), .Beat_o(beat), .StallCount_o(cnt)
  );
  hazard_control_unit #(.LANES(20)) dut_b1 (
    .CLK(clk), .RST(rst), .Valid_EX_i(valid), .OpType_EX_i(op), .RegFile_WE_EX_i(we),
    .WBSelect_EX_i(wbsel), .A3_EX_i(a3), .A1_ID_i(a1), .A2_ID_i(a2), .Use1_ID_i(use1),
    .Use2_ID_i(use2), .BranchTaken_EX_i(br), .Enable_PC_o(en_pc1), .Enable_IFID_o(en_ifid1),
    .Enable_IDEX_o(en_idex1), .Flush_IFID_o(fl_ifid1), .Flush_IDEX_o(fl_idex1),
    .Bubble_EXMEM_o(bub1), .Busy_o(busy1), .Beat_o(beat1), .StallCount_o(cnt1)
  );
  hazard_control_unit #(.CNT_W(2)) dut_c2 (
    .CLK(clk), .RST(rst), .Valid_EX_i(valid), .OpType_EX_i(op), .RegFile_WE_EX_i(we),
    .WBSelect_EX_i(wbsel), .A3_EX_i(a3), .A1_ID_i(a1), .A2_ID_i(a2), .Use1_ID_i(use1),
    .Use2_ID_i(use2), .BranchTaken_EX_i(br), .Enable_PC_o(en_pc2), .Enable_IFID_o(en_ifid2),
    .Enable_IDEX_o(en_idex2), .Flush_IFID_o(fl_ifid2), .Flush_IDEX_o(fl_idex2),
    .Bubble_EXMEM_o(bub2), .Busy_o(busy2), .Beat_o(beat2), .StallCount_o(cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One cycle: drive inputs, check at negedge, advance past the next posedge.
  // eo = {Enable_PC, Enable_IFID, Enable_IDEX, Flush_IFID, Flush_IDEX, Bubble_EXMEM, Busy}
  task automatic cyc(input string tag, input logic r, input logic v, input logic [1:0] o,
                     input logic w, input logic wb, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic u1, input logic u2, input logic b,
                     input logic [6:0] eo, input logic [2:0] eb, input logic [15:0] ec);
    rst = r; valid = v; op = o; we = w; wbsel = wb; a3 = d; a1 = s1; a2 = s2;
    use1 = u1; use2 = u2; br = b;
    @(negedge clk);
    chk({tag, ".out"}, 32'({en_pc, en_ifid, en_idex, fl_ifid, fl_idex, bub, busy}), 32'(eo));
    chk({tag, ".beat"}, 32'(beat), 32'(eb));
    chk({tag, ".cnt"}, 32'(cnt), 32'(ec));
    chk({tag, ".b1busy"}, 32'(busy1), 32'd0);
    @(posedge clk);
    #1;
  endtask
  localparam logic [6:0] NRM = 7'b1110000;
  localparam logic [6:0] VTRIG = 7'b0000010;
  localparam logic [6:0] VHOLD = 7'b0000011;
  localparam logic [6:0] VLAST = 7'b1110001;
  localparam logic [6:0] LUST = 7'b0010100;
  localparam logic [6:0] BRF = 7'b1111100;
  initial begin
    rst = 1'b1; valid = 0; op = 0; we = 0; wbsel = 0; a3 = 0; a1 = 0; a2 = 0;
    use1 = 0; use2 = 0; br = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
    cyc("v1t0", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VTRIG, 0, 0);
    for (int i = 1; i < 4; i++)
      cyc("v1hold", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VHOLD, 3'(i), 16'(i));
    cyc("v1last", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VLAST, 4, 4);
    cyc("v2t0", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VTRIG, 0, 4);
    for (int i = 1; i < 4; i++)
      cyc("v2hold", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VHOLD, 3'(i), 16'(4 + i));
    cyc("v2last", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VLAST, 4, 8);
    cyc("v2done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 8);
    chk("b1cnt_vec", 32'(cnt1), 32'd0);
    chk("c2sat_vec", 32'(cnt2), 32'd3);
    cyc("lu_a1", 0, 1, 0, 1, 1, 7, 7, 0, 1, 0, 0, LUST, 0, 8);
    cyc("lu_bub", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 9);
    cyc("lu_nouse", 0, 1, 0, 1, 1, 7, 7, 0, 0, 0, 0, NRM, 0, 9);
    cyc("lu_a2", 0, 1, 0, 1, 1, 7, 3, 7, 0, 1, 0, LUST, 0, 9);
    cyc("lu_bub2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 10);
    cyc("lu_r0", 0, 1, 0, 1, 1, 0, 0, 5, 1, 0, 0, LUST, 0, 10);
    cyc("nowe", 0, 1, 0, 0, 1, 7, 7, 0, 1, 0, 0, NRM, 0, 11);
    cyc("br_lu", 0, 1, 0, 1, 1, 7, 7, 0, 1, 0, 1, BRF, 0, 11);
    cyc("br_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 11);
    chk("b1cnt_lu", 32'(cnt1), 32'd3);
    chk("c2sat_lu", 32'(cnt2), 32'd3);
    cyc("r_t0", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VTRIG, 0, 11);
    cyc("r_t1", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, VHOLD, 1, 12);
    cyc("r_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 2, 13);
    cyc("r_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
    chk("b1cnt_rst", 32'(cnt1), 32'd0);
    chk("c2cnt_rst", 32'(cnt2), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Central stall/flush controller that drives the enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC. It inspects the ID/EX register outputs, the ID-stage source addresses and the EX-stage branch outcome. It holds the front of the pipeline while a multi-beat vector operation occupies EX, and inserts bubbles for load-use hazards and taken branches. The top level ORs each Flush_* output into the synchronous RST of the corresponding pipeline register.

## Interface
- V, 20, vector elements per vector register
- LANES, 4, elements processed by the EX vector ALU per cycle; B = ceil(V/LANES) beats per vector op (default 5)
- CNT_W, 16, width of the stall performance counter
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- Valid_EX_i  in  1  ID/EX register holds a real instruction (not a bubble)
- OpType_EX_i  in  2  OpType from ID/EX; 2'b01 = vector arithmetic, others scalar/memory
- RegFile_WE_EX_i  in  1  RegFile_WE from ID/EX
- WBSelect_EX_i  in  1  WBSelect from ID/EX; 1 = writeback from memory (load)
- A3_EX_i  in  5  destination register of the EX instruction
- A1_ID_i, A2_ID_i  in  5 each  source register addresses of the ID instruction
- Use1_ID_i, Use2_ID_i  in  1 each  ID instruction actually reads A1/A2
- BranchTaken_EX_i  in  1  branch in EX resolved taken this cycle
- Enable_PC_o  out  1  PC update enable
- Enable_IFID_o  out  1  IF/ID register enable
- Enable_IDEX_o  out  1  ID/EX register enable_i
- Flush_IFID_o  out  1  clear IF/ID next edge
- Flush_IDEX_o  out  1  clear ID/EX next edge
- Bubble_EXMEM_o  out  1  EX/MEM must capture a bubble (vector op not on last beat)
- Busy_o  out  1  vector op in progress (state BUSY)
- Beat_o  out  3  current vector beat index, 0..B-1
- StallCount_o  out  CNT_W  saturating count of cycles with Enable_PC_o = 0

## Operation
- Vector trigger VT = Valid_EX_i & OpType_EX_i==2'b01. Load-use LU = Valid_EX_i & RegFile_WE_EX_i & WBSelect_EX_i & ((Use1_ID_i & A1_ID_i==A3_EX_i) | (Use2_ID_i & A2_ID_i==A3_EX_i)). Register 0 gets no exemption.
- States:
  - IDLE: Beat_o = 0.
  - BUSY: Beat_o = beat register.
- Transitions:
  - IDLE -> BUSY when VT and B>1; beat register <= 1.
  - In BUSY, beat increments each cycle.
  - BUSY -> IDLE on the edge ending the cycle where Beat_o == B-1; beat <= 0.
  - B == 1: never leaves IDLE.
- Vector hold (VH) = VT & Beat_o < B-1, covering both the IDLE trigger cycle and BUSY.
- Output priority, evaluated combinationally every cycle:
  - BranchTaken_EX_i: all enables 1; Flush_IFID_o = Flush_IDEX_o = 1. VH is ignored. A branch never coincides with VT; if it does anyway, the FSM still advances.
  - Else VH: Enable_PC_o = Enable_IFID_o = Enable_IDEX_o = 0; no flush; Bubble_EXMEM_o = 1.
  - Else LU: Enable_PC_o = Enable_IFID_o = 0; Enable_IDEX_o = 1; Flush_IDEX_o = 1, which inserts one bubble.
  - Else: all enables 1, no flush, no bubble.
- Busy_o = (state == BUSY).
- StallCount_o increments by 1 on each edge where Enable_PC_o was 0 and RST is low; it saturates at all-ones.

## Timing
- All Enable/Flush/Bubble outputs are combinational from the current inputs and registered state, so they are valid in the same cycle as the hazard. State, beat and counter are registered.
- Vector op entering EX at cycle t (B=5):
  - Enable_IDEX_o = 0 for cycles t..t+3.
  - Beat_o = 0,1,2,3,4 across cycles t..t+4.
  - Enables return to 1 at t+4.
  - Total front-end stall = B-1 cycles.
- Back-to-back vector ops: the second enters EX at t+5 and retriggers from IDLE with no gap cycle.
- Load-use stall is exactly 1 cycle. The bubble in EX has Valid_EX_i = 0, so LU clears the next cycle.
- RST high at an edge:
  - state <= IDLE, beat <= 0, StallCount_o <= 0.
  - While RST is high, all enables are 0 and Flush/Bubble/Busy are 0.
  - Reset mid-vector abandons the op; the first cycle after reset is IDLE.
- Reset values: Busy_o 0, Beat_o 0, StallCount_o 0.

## Test plan
- Vector op in EX for one cycle after IDLE, B=5 -> Enable_IDEX_o low t..t+3, Beat_o 0..4, Busy_o high t+1..t+4, StallCount_o = 4.
- Load followed by dependent ID read (A3_EX=7, A1_ID=7, Use1=1) -> one cycle with Enable_PC_o=0 and Flush_IDEX_o=1, then normal flow. Same case with Use1=0 -> no stall.
- BranchTaken_EX_i=1 while LU is also true -> both flushes 1, all enables 1, StallCount_o unchanged.
- RST asserted at Beat_o=2 -> next cycle Busy_o=0, Beat_o=0, StallCount_o=0, enables 1 after RST is released.
- LANES=20 (B=1) with a vector op in EX -> never BUSY, no stall. Two consecutive vector ops with B=5 -> 8 stall cycles, Beat_o restarts at 0.
- CNT_W=2 with 5 stall cycles -> StallCount_o saturates at 3.
